// File: rtl/guess_controller.sv
// Guess front-end for the hangman letter tracker: filters submits, issues one load
// per accepted letter, waits for the tracker verdict and tracks misses / game end.
module guess_controller #(
    parameter int MAX_MISSES  = 6,
    parameter int CHECK_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  letter,
    input  logic        submit,
    input  logic [25:0] current_state,
    input  logic        wrong,
    input  logic        win,
    output logic        load,
    output logic [4:0]  load_x,
    output logic [3:0]  misses,
    output logic        busy,
    output logic        reject,
    output logic        game_won,
    output logic        game_lost,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_WON   = 3'd4,
        S_LOST  = 3'd5
    } state_t;

    state_t      state, state_n;
    logic        submit_q;
    logic [4:0]  load_x_q, load_x_n;
    logic [3:0]  misses_q, misses_n;
    logic [2:0]  cnt_q, cnt_n;
    logic        reject_q, reject_n;
    logic        submit_edge;
    logic        guess_ok;
    logic [31:0] guessed_ext;
    logic [4:0]  misses_inc;
    logic        lose_now;

    // Widened so letters 26..31 index a defined (zero) bit; they are refused anyway.
    assign guessed_ext = {6'b0, current_state};
    assign submit_edge = submit & ~submit_q;
    assign guess_ok    = (letter <= 5'd25) && !guessed_ext[letter];
    assign misses_inc  = {1'b0, misses_q} + 5'd1;
    assign lose_now    = misses_inc >= 5'(MAX_MISSES);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt_q;
        reject_n = 1'b0;
        load_x_n = load_x_q;
        misses_n = misses_q;
        case (state)
            S_IDLE: begin
                if (submit_edge) begin
                    if (guess_ok) begin
                        load_x_n = letter;
                        state_n  = S_LOAD;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cnt_n   = 3'(CHECK_DELAY - 1);
                state_n = (CHECK_DELAY <= 1) ? S_CHECK : S_WAIT;
            end
            // WAIT lasts CHECK_DELAY-1 cycles so CHECK lands CHECK_DELAY after LOAD.
            S_WAIT: begin
                if (cnt_q <= 3'd1) state_n = S_CHECK;
                else               cnt_n   = cnt_q - 3'd1;
            end
            S_CHECK: begin
                if (win) begin
                    state_n = S_WON;
                end else if (wrong) begin
                    misses_n = lose_now ? 4'(MAX_MISSES) : misses_inc[3:0];
                    state_n  = lose_now ? S_LOST : S_IDLE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_WON:   state_n = S_WON;
            S_LOST:  state_n = S_LOST;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            submit_q <= 1'b0;
            load_x_q <= 5'd0;
            misses_q <= 4'd0;
            cnt_q    <= 3'd0;
            reject_q <= 1'b0;
        end else begin
            state    <= state_n;
            submit_q <= submit;
            load_x_q <= load_x_n;
            misses_q <= misses_n;
            cnt_q    <= cnt_n;
            reject_q <= reject_n;
        end
    end

    assign load      = (state == S_LOAD);
    assign busy      = (state == S_LOAD) || (state == S_WAIT) || (state == S_CHECK);
    assign game_won  = (state == S_WON);
    assign game_lost = (state == S_LOST);
    assign load_x    = load_x_q;
    assign misses    = misses_q;
    assign reject    = reject_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_guess_controller.sv
// Bench for guess_controller: directed guesses, expected events queued by the
// driver and popped by a negedge monitor on load / reject / verdict.
module tb_guess_controller;

  localparam int CD = 2;
  localparam int MM = 6;
  localparam int W  = 10;
  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_REJ  = 2'd1;
  localparam logic [1:0] K_VER  = 2'd2;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd2, ST_CHECK = 3'd3,
                         ST_WON = 3'd4, ST_LOST = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  letter = 5'd0;
  logic        submit = 1'b0;
  logic [25:0] current_state = 26'd0;
  logic        wrong = 1'b0;
  logic        win = 1'b0;
  logic        load;
  logic [4:0]  load_x;
  logic [3:0]  misses;
  logic        busy;
  logic        reject;
  logic        game_won;
  logic        game_lost;
  logic [2:0]  fsm_state;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  guess_controller #(.MAX_MISSES(MM), .CHECK_DELAY(CD)) dut (
    .clk(clk), .reset(reset), .letter(letter), .submit(submit),
    .current_state(current_state), .wrong(wrong), .win(win),
    .load(load), .load_x(load_x), .misses(misses), .busy(busy),
    .reject(reject), .game_won(game_won), .game_lost(game_lost),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1;
    submit = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_load"}, 32'(load), 32'd0);
    check({tag, "_load_x"}, 32'(load_x), 32'd0);
    check({tag, "_misses"}, 32'(misses), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_reject"}, 32'(reject), 32'd0);
    check({tag, "_won"}, 32'(game_won), 32'd0);
    check({tag, "_lost"}, 32'(game_lost), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
  endtask

  // expectation pushers
  task automatic exp_load(input logic [4:0] l);
    exp_q.push_back({K_LOAD, 3'b000, l});
  endtask
  task automatic exp_rej();
    exp_q.push_back({K_REJ, 8'd0});
  endtask
  task automatic exp_ver(input logic won, input logic lost, input logic [3:0] m);
    exp_q.push_back({K_VER, 2'b00, won, lost, m});
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL wait_idle: busy still %0d after 60 cycles, expected 0", busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge; holds submit high for 'hold' cycles.
  task automatic guess(input logic [4:0] l, input logic w, input logic wn, input int hold);
    letter = l;
    wrong  = w;
    win    = wn;
    submit = 1'b1;
    repeat (hold) @(posedge clk);
    #1 submit = 1'b0;
    wait_idle();
  endtask

  // monitor: pops one expectation per observed event
  logic       busy_prev = 1'b0;
  int         busy_len = 0;
  logic [W-1:0] act_ev;
  logic [W-1:0] exp_ev;

  task automatic sb_compare(input string name, input logic [W-1:0] act);
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event %0h, expected none", name, act);
    end else begin
      exp_ev = exp_q.pop_front();
      if (act !== exp_ev) begin
        fails++;
        $display("FAIL %s: got %0h expected %0h", name, act, exp_ev);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if (busy) busy_len++;
      if (load) begin
        act_ev = {K_LOAD, 3'b000, load_x};
        sb_compare("load", act_ev);
      end
      if (reject) begin
        act_ev = {K_REJ, 8'd0};
        sb_compare("reject", act_ev);
      end
      if (busy_prev && !busy) begin
        act_ev = {K_VER, 2'b00, game_won, game_lost, misses};
        sb_compare("verdict", act_ev);
        check("busy_len", 32'(busy_len), 32'(1 + CD));
        busy_len = 0;
      end
      busy_prev = busy;
    end
  end

  initial begin
    // reset state
    reset_dut();
    check_reset_values("rst");

    // single guess held high for 10 cycles: one load, no miss
    exp_load(5'd3);
    exp_ver(1'b0, 1'b0, 4'd0);
    guess(5'd3, 1'b0, 1'b0, 10);
    check("t1_load_x_stable", 32'(load_x), 32'd3);
    check("t1_misses", 32'(misses), 32'd0);
    check("t1_state", 32'(fsm_state), 32'(ST_IDLE));

    // duplicate and out-of-range letters are refused
    current_state = 26'd1 << 7;
    exp_rej();
    guess(5'd7, 1'b0, 1'b0, 1);
    exp_rej();
    guess(5'd28, 1'b0, 1'b0, 1);
    check("rej_busy", 32'(busy), 32'd0);
    current_state = 26'd0;

    // six misses lose the game; letter 25 is the valid boundary
    for (int k = 1; k <= MM; k++) begin
      logic [4:0] l;
      l = (k == MM) ? 5'd25 : 5'(9 + k);
      exp_load(l);
      exp_ver(1'b0, (k == MM), 4'(k));
      guess(l, 1'b1, 1'b0, 2);
    end
    check("lost_flag", 32'(game_lost), 32'd1);
    check("lost_misses", 32'(misses), 32'(MM));
    guess(5'd20, 1'b0, 1'b0, 1);
    check("lost_state", 32'(fsm_state), 32'(ST_LOST));
    check("lost_misses_sat", 32'(misses), 32'(MM));

    // win beats simultaneous wrong
    reset_dut();
    exp_load(5'd4);
    exp_ver(1'b1, 1'b0, 4'd0);
    guess(5'd4, 1'b1, 1'b1, 1);
    check("won_state", 32'(fsm_state), 32'(ST_WON));
    check("won_misses", 32'(misses), 32'd0);
    guess(5'd6, 1'b0, 1'b0, 1);
    check("won_sticky", 32'(game_won), 32'd1);

    // submit edge during WAIT is dropped; then letter 0 loads normally
    reset_dut();
    exp_load(5'd5);
    exp_ver(1'b0, 1'b0, 4'd0);
    letter = 5'd5; wrong = 1'b0; win = 1'b0; submit = 1'b1;
    @(posedge clk); #1 submit = 1'b0;
    @(posedge clk); #1;
    check("midwait_state", 32'(fsm_state), 32'(ST_WAIT));
    submit = 1'b1; letter = 5'd6;
    @(posedge clk); #1;
    check("midwait_to_check", 32'(fsm_state), 32'(ST_CHECK));
    submit = 1'b0;
    wait_idle();
    exp_load(5'd0);
    exp_ver(1'b0, 1'b0, 4'd0);
    guess(5'd0, 1'b0, 1'b0, 1);
    check("letter0_load_x", 32'(load_x), 32'd0);

    // reset mid-WAIT discards a pending wrong verdict
    exp_load(5'd8);
    exp_ver(1'b0, 1'b0, 4'd1);
    guess(5'd8, 1'b1, 1'b0, 1);
    exp_load(5'd9);
    letter = 5'd9; submit = 1'b1;
    @(posedge clk); #1 submit = 1'b0;
    @(posedge clk); #1;
    check("rstwait_state", 32'(fsm_state), 32'(ST_WAIT));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_values("rstwait");
    wrong = 1'b0;
    @(posedge clk); #1;
    exp_load(5'd9);
    exp_ver(1'b0, 1'b0, 4'd0);
    guess(5'd9, 1'b0, 1'b0, 1);
    check("post_rst_misses", 32'(misses), 32'd0);

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
